snac_db9md_scanner: RTL and testbench
=====================================

Name: snac_db9md_scanner

Overview:
- Scan controller for the Serial SNAC DB9 port. Two Mega Drive pads share one 6-line input bus through an external splitter.
- Drives joy_split (port select) and joy_mdsel (Sega SELECT line) through a fixed 8-phase 6-button protocol, first on port 1 and then on port 2.
- Latches debounced, active-high button words for both players, in the 16-bit joystick format consumed by the core input mux.
- Sits between USER_IN/USER_OUT and the per-player control mapping. Runs on clk_sys.

Parameters:
- PHASE_CYC, 240: clk_sys cycles per SELECT phase (10 us at 24 MHz). Must be >= 4.
- SPLIT_CYC, 240: settle cycles after toggling joy_split. Must be >= 4.
- IDLE_CYC, 48000: cycles with SELECT high between frames (2 ms). This resets the pad's 6-button counter. Must be >= 4.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- scan_en  in  1  1 = scanning allowed (status[31:30] != 0)
- two_port  in  1  1 = scan port 2 as well; 0 = port 1 only
- joy_in  in  6  raw pad lines, active-low: [0]up [1]down [2]left [3]right [4]pin6 (B/A) [5]pin9 (C/Start)
- joy_split  out  1  1 = port 1 routed to joy_in, 0 = port 2
- joy_mdsel  out  1  Sega SELECT line
- joystick1  out  16  player 1 buttons, active-high
- joystick2  out  16  player 2 buttons, active-high
- present  out  2  [0] pad detected on port 1, [1] on port 2
- six_btn  out  2  6-button pad detected per port
- frame_stb  out  1  one-cycle pulse when a full frame completes

Behaviour:
- Reset values (while reset_n=0): joy_split=1, joy_mdsel=1, joystick1/2=0, present=0, six_btn=0, frame_stb=0. FSM in IDLE with its counter cleared.
- joy_in passes through a 2-FF synchronizer. Inputs are sampled on the last cycle of each phase (cycle PHASE_CYC-1).
- Joystick word bit map: [0]R [1]L [2]D [3]U [4]B [5]C [6]A [7]Start [8]Mode [9]X [10]Y [11]Z; bits [15:12] are always 0.
- FSM states and transitions:
  - IDLE: joy_mdsel=1. Counts IDLE_CYC cycles. At the end, if scan_en=1, go to SCAN with port=1 and joy_split=1; otherwise stay in IDLE with the counter held at 0.
  - SCAN: phases 0..7, each PHASE_CYC cycles long. joy_mdsel = 1 in even phases and 0 in odd phases.
  - SWITCH: only entered after port 1 when two_port=1. Sets joy_split=0 on entry and waits SPLIT_CYC cycles with joy_mdsel=1, then goes to SCAN with port=2.
- Per-phase sampling (active-low inputs inverted, into a shadow register):
  - Phase 0: U, D, L, R, B=pin6, C=pin9.
  - Phase 1: A=pin6, Start=pin9. Pad detected = raw left AND raw right both low.
  - Phase 5: six-button detected = raw up, down, left, right all low.
  - Phase 6: only when six-button was detected: Z=up, Y=down, X=left, Mode=right. Otherwise these bits are 0.
  - Phases 2, 3, 4, 7: no sampling.
- Commit at the end of phase 7, when the shadow register is copied to the port's outputs:
  - Pad detected: joystickN = shadow, present[N]=1, six_btn[N] = six-button flag.
  - No pad: joystickN=0, present[N]=0, six_btn[N]=0.
- After the port 1 commit: go to SWITCH if two_port=1. Otherwise the frame ends.
- After the port 2 commit: set joy_split=1, then the frame ends.
- Frame end: pulse frame_stb for one cycle and go to IDLE.
- Outputs change only at a commit. A port's bits are never partially updated.
- two_port=0: joystick2, present[1] and six_btn[1] are forced to 0 at each frame end.
- scan_en deasserting mid-frame: the current frame completes normally, then the FSM stays in IDLE. joystick1/2 hold their last values.
- scan_en rising: the first scan starts only after a full IDLE_CYC period, so the pad counter is always reset first.
- Frame length in clk_sys cycles = IDLE_CYC + 8·PHASE_CYC + (two_port ? SPLIT_CYC + 8·PHASE_CYC : 0).
- Asynchronous reset mid-frame: immediate return to the reset values above.

Test Plan:
All scenarios use PHASE_CYC=4, SPLIT_CYC=4, IDLE_CYC=16, so a two-port frame is 84 cycles.
- Reset, scan_en=1, two_port=1, both pad models idle (3-button) -> joy_mdsel toggles 1,0 every 4 cycles for 8 phases; joy_split falls at cycle 48 and rises at cycle 84; frame_stb pulses at cycle 84; present=2'b11, six_btn=2'b00.
- Port 1 is a 6-button model with A, Start and Z pressed -> after the first frame, joystick1=16'h08C0 and six_btn[0]=1.
- Port 2 has no pad (all lines high), two_port=1 -> joystick2=0 and present[1]=0; port 1 data is unaffected.
- two_port=0 -> joy_split stays 1 for the whole run; frame is 48 cycles; joystick2 is forced to 0.
- Clear scan_en during port 1 phase 3 -> the frame still completes and pulses frame_stb; joy_mdsel then holds 1 and no further commits occur.
- Assert reset_n=0 during port 2 phase 5 -> joy_split=1, joy_mdsel=1 and all outputs are 0 asynchronously. After release, the first commit happens no earlier than 16+32 cycles.

Source files
------------

// File: rtl/snac_db9md_scanner_if.sv
// Signal bundle between the DB9 Mega Drive scanner, the SNAC pad lines and the core input mux.
interface snac_db9md_scanner_if;
  logic        scan_en;
  logic        two_port;
  logic [5:0]  joy_in;
  logic        joy_split;
  logic        joy_mdsel;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  present;
  logic [1:0]  six_btn;
  logic        frame_stb;

  modport master (
    input  scan_en, two_port, joy_in,
    output joy_split, joy_mdsel, joystick1, joystick2, present, six_btn, frame_stb
  );

  modport slave (
    output scan_en, two_port, joy_in,
    input  joy_split, joy_mdsel, joystick1, joystick2, present, six_btn, frame_stb
  );
endinterface

// File: rtl/snac_db9md_scanner.sv
// Scans one or two Mega Drive pads behind a DB9 splitter with the 8-phase 6-button
// SELECT protocol and publishes active-high joystick words once per frame.
module snac_db9md_scanner #(
  parameter int PHASE_CYC = 240,
  parameter int SPLIT_CYC = 240,
  parameter int IDLE_CYC  = 48000
) (
  input  logic clk_sys,
  input  logic reset_n,
  snac_db9md_scanner_if.master bus
);

  localparam int MAX_PS  = (PHASE_CYC > SPLIT_CYC) ? PHASE_CYC : SPLIT_CYC;
  localparam int MAX_CYC = (IDLE_CYC > MAX_PS) ? IDLE_CYC : MAX_PS;
  localparam int CNT_W   = $clog2(MAX_CYC);

  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] SPLIT_LAST = CNT_W'(SPLIT_CYC - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SWITCH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       phase;
  logic             port2;
  logic [11:0]      shadow;
  logic             pad_det;
  logic             six_det;
  logic [5:0]       sync1;
  logic [5:0]       sync2;
  logic [5:0]       act;

  assign act = ~sync2;

  // Idle pad lines float high, so the synchronizer resets to all ones.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= bus.joy_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      phase         <= '0;
      port2         <= 1'b0;
      shadow        <= '0;
      pad_det       <= 1'b0;
      six_det       <= 1'b0;
      bus.joy_split <= 1'b1;
      bus.joy_mdsel <= 1'b1;
      bus.joystick1 <= '0;
      bus.joystick2 <= '0;
      bus.present   <= '0;
      bus.six_btn   <= '0;
      bus.frame_stb <= 1'b0;
    end else begin
      bus.frame_stb <= 1'b0;
      case (state)
        // A full idle period with SELECT high always precedes a scan so the pad's
        // 6-button counter has timed out.
        IDLE: begin
          bus.joy_mdsel <= 1'b1;
          if (!bus.scan_en) begin
            cnt <= '0;
          end else if (cnt == IDLE_LAST) begin
            cnt           <= '0;
            state         <= SCAN;
            phase         <= '0;
            port2         <= 1'b0;
            bus.joy_split <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SWITCH: begin
          bus.joy_mdsel <= 1'b1;
          if (cnt == SPLIT_LAST) begin
            cnt   <= '0;
            state <= SCAN;
            phase <= '0;
            port2 <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SCAN: begin
          if (cnt != PHASE_LAST) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            case (phase)
              3'd0: shadow[5:0] <= {act[5], act[4], act[0], act[1], act[2], act[3]};
              3'd1: begin
                shadow[7:6] <= {act[5], act[4]};
                pad_det     <= act[2] & act[3];
              end
              3'd5: six_det <= &act[3:0];
              3'd6: shadow[11:8] <= six_det ? {act[0], act[1], act[2], act[3]} : 4'h0;
              default: ;
            endcase

            if (phase != 3'd7) begin
              phase         <= phase + 3'd1;
              bus.joy_mdsel <= phase[0];
            end else begin
              // Every bit of a port is committed together from the shadow copy.
              bus.joy_mdsel <= 1'b1;
              if (!port2) begin
                bus.joystick1  <= pad_det ? {4'h0, shadow} : 16'h0000;
                bus.present[0] <= pad_det;
                bus.six_btn[0] <= pad_det & six_det;
              end else begin
                bus.joystick2  <= pad_det ? {4'h0, shadow} : 16'h0000;
                bus.present[1] <= pad_det;
                bus.six_btn[1] <= pad_det & six_det;
              end

              if (!port2 && bus.two_port) begin
                state         <= SWITCH;
                bus.joy_split <= 1'b0;
              end else begin
                state         <= IDLE;
                bus.joy_split <= 1'b1;
                bus.frame_stb <= 1'b1;
                if (!bus.two_port) begin
                  bus.joystick2  <= 16'h0000;
                  bus.present[1] <= 1'b0;
                  bus.six_btn[1] <= 1'b0;
                end
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snac_db9md_scanner.sv
// Bench for the DB9 Mega Drive scanner: two behavioural pads behind a splitter,
// a vector table (hand-picked plus random) and a few multi-cycle sequences.
module tb_snac_db9md_scanner;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk_sys = ~clk_sys;

  snac_db9md_scanner_if bus();

  snac_db9md_scanner #(
    .PHASE_CYC(4),
    .SPLIT_CYC(4),
    .IDLE_CYC (16)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Pad configuration: kind 0 = nothing plugged, 1 = 3-button, 2 = 6-button.
  // Buttons use the joystick word bit order (R L D U B C A St Mode X Y Z).
  logic [1:0]  k1 = 2'd1;
  logic [1:0]  k2 = 2'd1;
  logic [11:0] b1 = 12'h000;
  logic [11:0] b2 = 12'h000;

  // Each pad sees SELECT only while the splitter routes it; otherwise its SELECT idles high.
  logic sel1, sel2;
  assign sel1 = bus.joy_split ? bus.joy_mdsel : 1'b1;
  assign sel2 = bus.joy_split ? 1'b1 : bus.joy_mdsel;

  int   cnt1 = 0, cnt2 = 0, hi1 = 0, hi2 = 0;
  logic prev1 = 1'b1, prev2 = 1'b1;

  // Pad state: count SELECT falling edges, reset after SELECT stays high long enough.
  always @(posedge clk_sys) begin
    if (prev1 && !sel1 && cnt1 < 7) cnt1 <= cnt1 + 1;
    if (sel1 && hi1 >= 12) cnt1 <= 0;
    hi1   <= sel1 ? ((hi1 < 255) ? hi1 + 1 : hi1) : 0;
    prev1 <= sel1;
    if (prev2 && !sel2 && cnt2 < 7) cnt2 <= cnt2 + 1;
    if (sel2 && hi2 >= 12) cnt2 <= 0;
    hi2   <= sel2 ? ((hi2 < 255) ? hi2 + 1 : hi2) : 0;
    prev2 <= sel2;
  end

  function automatic logic [5:0] padLines(input logic [1:0] kind, input logic [11:0] b,
                                          input logic sel, input int cnt);
    logic [5:0] p;
    p = 6'h00;
    if (kind == 2'd0) return 6'h3F;
    if (sel) begin
      if (kind == 2'd2 && cnt == 3) p = {b[5], b[4], b[8], b[9], b[10], b[11]};
      else                          p = {b[5], b[4], b[0], b[1], b[2], b[3]};
    end else begin
      if (kind == 2'd2 && cnt == 3)      p = {b[7], b[6], 4'hF};
      else if (kind == 2'd2 && cnt == 4) p = {b[7], b[6], 4'h0};
      else                               p = {b[7], b[6], 2'b11, b[2], b[3]};
    end
    return ~p;
  endfunction

  assign bus.joy_in = bus.joy_split ? padLines(k1, b1, sel1, cnt1) : padLines(k2, b2, sel2, cnt2);

  // Reference: what the core should see for a given pad and held buttons.
  function automatic logic [15:0] refWord(input logic [1:0] kind, input logic [11:0] b);
    if (kind == 2'd0) return 16'h0000;
    if (kind == 2'd1) return {8'h00, b[7:0]};
    return {4'h0, b};
  endfunction

  function automatic logic [11:0] fixDpad(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    if (r[3] && r[2]) r[2] = 1'b0;
    return r;
  endfunction

  task automatic applyStimulus(input logic tp, input logic [1:0] kk1, input logic [11:0] bb1,
                               input logic [1:0] kk2, input logic [11:0] bb2);
    bus.two_port = tp;
    k1 = kk1;
    b1 = bb1;
    k2 = kk2;
    b2 = bb2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic waitFrame(output int len, output logic split_low, output logic mdsel_low);
    len       = 0;
    split_low = 1'b0;
    mdsel_low = 1'b0;
    do begin
      @(negedge clk_sys);
      len++;
      if (!bus.joy_split) split_low = 1'b1;
      if (!bus.joy_mdsel) mdsel_low = 1'b1;
    end while (!bus.frame_stb && len < 400);
    if (!bus.frame_stb) begin
      checks_total++;
      $display("[TB] FAIL frame_timeout: got no frame_stb within %0d cycles, expected one", len);
    end
  endtask

  typedef struct {
    logic        tp;
    logic [1:0]  k1;
    logic [11:0] b1;
    logic [1:0]  k2;
    logic [11:0] b2;
    logic [15:0] e_j1;
    logic [15:0] e_j2;
    logic [1:0]  e_pres;
    logic [1:0]  e_six;
    int          e_len;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  logic mtr[0:90];
  logic str[0:90];
  logic btr[0:90];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   len, bad_m, bad_s, bad_b, hold_cyc;
    logic sl, ml, seen_low, seen_stb;
    logic [15:0] p_j1, p_j2;
    logic [1:0]  p_pres, p_six;

    vecs[0] = '{1'b1, 2'd2, 12'h8C0, 2'd1, 12'h000, 16'h08C0, 16'h0000, 2'b11, 2'b01, 84};
    vecs[1] = '{1'b1, 2'd2, 12'h8C0, 2'd0, 12'h000, 16'h08C0, 16'h0000, 2'b01, 2'b01, 84};
    vecs[2] = '{1'b0, 2'd1, 12'h013, 2'd2, 12'hFFF, 16'h0013, 16'h0000, 2'b01, 2'b00, 48};
    vecs[3] = '{1'b1, 2'd0, 12'h000, 2'd2, 12'h3A4, 16'h0000, 16'h03A4, 2'b10, 2'b10, 84};
    vecs[4] = '{1'b1, 2'd1, 12'hF3A, 2'd2, 12'h6C9, 16'h003A, 16'h06C9, 2'b11, 2'b10, 84};
    vecs[5] = '{1'b0, 2'd2, 12'h001, 2'd2, 12'h0FF, 16'h0001, 16'h0000, 2'b01, 2'b01, 48};
    for (int i = 6; i < NVEC; i++) begin
      vecs[i].tp     = 1'($urandom_range(0, 1));
      vecs[i].k1     = 2'($urandom_range(0, 2));
      vecs[i].k2     = 2'($urandom_range(0, 2));
      vecs[i].b1     = fixDpad(12'($urandom));
      vecs[i].b2     = fixDpad(12'($urandom));
      vecs[i].e_j1   = refWord(vecs[i].k1, vecs[i].b1);
      vecs[i].e_j2   = vecs[i].tp ? refWord(vecs[i].k2, vecs[i].b2) : 16'h0000;
      vecs[i].e_pres = {vecs[i].tp && vecs[i].k2 != 2'd0, vecs[i].k1 != 2'd0};
      vecs[i].e_six  = {vecs[i].tp && vecs[i].k2 == 2'd2, vecs[i].k1 == 2'd2};
      vecs[i].e_len  = vecs[i].tp ? 84 : 48;
    end

    bus.scan_en = 1'b1;
    applyStimulus(1'b1, 2'd1, 12'h000, 2'd1, 12'h000);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    checkOutput("reset_ctrl", {bus.joy_split, bus.joy_mdsel, bus.present, bus.six_btn, bus.frame_stb},
                7'b1100000);
    checkOutput("reset_joy", {bus.joystick1, bus.joystick2}, 32'h0);

    // First frame, traced cycle by cycle from reset release.
    reset_n = 1'b1;
    for (int c = 0; c <= 90; c++) begin
      if (c > 0) @(negedge clk_sys);
      mtr[c] = bus.joy_mdsel;
      str[c] = bus.joy_split;
      btr[c] = bus.frame_stb;
      if (c == 84) begin
        p_j1   = bus.joystick1;
        p_j2   = bus.joystick2;
        p_pres = bus.present;
        p_six  = bus.six_btn;
      end
    end
    bad_m = -1;
    bad_s = -1;
    bad_b = -1;
    for (int c = 0; c <= 90; c++) begin
      logic em;
      em = 1'b1;
      if (c >= 16 && c < 48) em = (((c - 16) / 4) % 2) == 0;
      if (c >= 52 && c < 84) em = (((c - 52) / 4) % 2) == 0;
      if (bad_m < 0 && mtr[c] !== em) bad_m = c;
      if (bad_s < 0 && str[c] !== !(c >= 48 && c < 84)) bad_s = c;
      if (bad_b < 0 && btr[c] !== (c == 84)) bad_b = c;
    end
    checkOutput("mdsel_trace_first_bad_cycle", bad_m, -1);
    checkOutput("split_trace_first_bad_cycle", bad_s, -1);
    checkOutput("stb_trace_first_bad_cycle", bad_b, -1);
    checkOutput("first_frame_present_six", {p_pres, p_six}, 4'b1100);
    checkOutput("first_frame_joy", {p_j1, p_j2}, 32'h0);

    waitFrame(len, sl, ml);
    checkOutput("second_frame_len", len, 78);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].tp, vecs[i].k1, vecs[i].b1, vecs[i].k2, vecs[i].b2);
      waitFrame(len, sl, ml);
      checkOutput($sformatf("vec%0d_joystick1", i), bus.joystick1, vecs[i].e_j1);
      checkOutput($sformatf("vec%0d_joystick2", i), bus.joystick2, vecs[i].e_j2);
      checkOutput($sformatf("vec%0d_present", i), bus.present, vecs[i].e_pres);
      checkOutput($sformatf("vec%0d_six_btn", i), bus.six_btn, vecs[i].e_six);
      checkOutput($sformatf("vec%0d_frame_len", i), len, vecs[i].e_len);
      checkOutput($sformatf("vec%0d_split_went_low", i), sl, vecs[i].tp);
    end

    // scan_en dropped during port 1 phase 3: the frame still finishes.
    applyStimulus(1'b1, 2'd2, 12'h0A5, 2'd1, 12'h030);
    repeat (29) @(negedge clk_sys);
    bus.scan_en = 1'b0;
    waitFrame(len, sl, ml);
    checkOutput("scan_off_frame_len", len, 55);
    checkOutput("scan_off_joystick1", bus.joystick1, 16'h00A5);
    checkOutput("scan_off_joystick2", bus.joystick2, 16'h0030);

    applyStimulus(1'b1, 2'd1, 12'h0F3, 2'd1, 12'h0C8);
    seen_low = 1'b0;
    seen_stb = 1'b0;
    for (hold_cyc = 0; hold_cyc < 200; hold_cyc++) begin
      @(negedge clk_sys);
      if (!bus.joy_mdsel) seen_low = 1'b1;
      if (bus.frame_stb) seen_stb = 1'b1;
    end
    checkOutput("idle_mdsel_went_low", seen_low, 1'b0);
    checkOutput("idle_frame_stb_seen", seen_stb, 1'b0);
    checkOutput("idle_hold_joy", {bus.joystick1, bus.joystick2}, 32'h00A5_0030);

    // Rising scan_en starts a full idle period before the first scan.
    bus.scan_en = 1'b1;
    waitFrame(len, sl, ml);
    checkOutput("scan_on_frame_len", len, 84);
    checkOutput("scan_on_joy", {bus.joystick1, bus.joystick2}, 32'h00F3_00C8);
    checkOutput("scan_on_present_six", {bus.present, bus.six_btn}, 4'b1100);

    // Reset during port 2 phase 5.
    repeat (73) @(negedge clk_sys);
    checkOutput("pre_reset_split", bus.joy_split, 1'b0);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_ctrl", {bus.joy_split, bus.joy_mdsel, bus.present, bus.six_btn, bus.frame_stb},
                7'b1100000);
    checkOutput("async_reset_joy", {bus.joystick1, bus.joystick2}, 32'h0);
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    len = 0;
    while (bus.present == 2'b00 && len < 200) begin
      @(negedge clk_sys);
      len++;
    end
    checkOutput("post_reset_first_commit_cycle", len, 48);
    checkOutput("post_reset_port1_commit", {bus.joystick1, bus.joystick2, 2'b00, bus.present},
                {16'h00F3, 16'h0000, 4'b0001});

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
